// File: rtl/bb_pkg.sv
// Shared constants and state encoding for the blackbox self-test sweeper.
package bb_pkg;

  localparam int unsigned BB_NVEC = 8;
  localparam int unsigned BB_IDXW = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StDone  = 2'd2
  } bb_state_e;

endpackage

// File: rtl/blackbox_sweeper_if.sv
// Control, result and blackbox-facing signals of the sweeper.
// The master modport is the parent side; the slave modport is the sweeper itself.
interface blackbox_sweeper_if;
  import bb_pkg::*;

  logic               start;
  logic [BB_NVEC-1:0] expected;
  logic               p_in;
  logic               m_out;
  logic               b_out;
  logic               t_out;
  logic               busy;
  logic               done;
  logic [BB_NVEC-1:0] truth;
  logic               match;
  logic [BB_IDXW-1:0] fail_idx;

  modport master (
    output start, expected, p_in,
    input  m_out, b_out, t_out, busy, done, truth, match, fail_idx
  );

  modport slave (
    input  start, expected, p_in,
    output m_out, b_out, t_out, busy, done, truth, match, fail_idx
  );

endinterface

// File: rtl/bb_first_mismatch.sv
// Priority encoder over the truth/expected difference: lowest set bit wins.
module bb_first_mismatch
  import bb_pkg::*;
(
  input  logic [BB_NVEC-1:0] diff,
  output logic [BB_IDXW-1:0] fail_idx,
  output logic               zero
);

  // Scan from the top down so the lowest mismatching index is the last assignment.
  always_comb begin
    fail_idx = '0;
    for (int i = BB_NVEC - 1; i >= 0; i--) begin
      if (diff[i]) fail_idx = BB_IDXW'(i);
    end
    zero = (diff == '0);
  end

endmodule

// File: rtl/blackbox_sweeper.sv
// Self-test controller: walks blackbox through all input vectors, builds the
// truth table and compares it with a golden table.
module blackbox_sweeper
  import bb_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input logic               clock,
  input logic               reset_n,
  blackbox_sweeper_if.slave bus
);

  localparam logic [3:0]         SettleLast = 4'(SETTLE - 1);
  localparam logic [BB_IDXW-1:0] IdxLast    = BB_IDXW'(BB_NVEC - 1);

  bb_state_e          state_q, state_d;
  logic [BB_IDXW-1:0] idx_q, idx_d;
  logic [3:0]         cnt_q, cnt_d;
  // Set after the final sample so match/fail_idx see the complete registered table.
  logic               last_q, last_d;
  logic [BB_NVEC-1:0] truth_q, truth_d;
  logic [BB_NVEC-1:0] exp_q, exp_d;
  logic               match_q, match_d;
  logic [BB_IDXW-1:0] fail_q, fail_d;
  logic [BB_IDXW-1:0] mbt_q, mbt_d;

  logic [BB_NVEC-1:0] diff;
  logic [BB_IDXW-1:0] mm_idx;
  logic               mm_zero;

  assign diff = truth_q ^ exp_q;

  bb_first_mismatch u_first_mismatch (
    .diff     (diff),
    .fail_idx (mm_idx),
    .zero     (mm_zero)
  );

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      truth_q <= '0;
      exp_q   <= '0;
      match_q <= 1'b0;
      fail_q  <= '0;
      mbt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      truth_q <= truth_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      fail_q  <= fail_d;
      mbt_q   <= mbt_d;
    end
  end

  // Next-state logic for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    truth_d = truth_q;
    exp_d   = exp_q;
    match_d = match_q;
    fail_d  = fail_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StDrive;
          idx_d   = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
          truth_d = '0;
          match_d = 1'b0;
          fail_d  = '0;
          exp_d   = bus.expected;
        end
      end
      StDrive: begin
        if (last_q) begin
          state_d = StDone;
          last_d  = 1'b0;
          match_d = mm_zero;
          fail_d  = mm_idx;
        end else if (cnt_q == SettleLast) begin
          truth_d[idx_q] = bus.p_in;
          cnt_d          = '0;
          if (idx_q == IdxLast) last_d = 1'b1;
          else                  idx_d  = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase

    // Registered vector so blackbox sees clean, glitch-free inputs.
    mbt_d = (state_d == StDrive) ? idx_d : '0;
  end

  assign bus.m_out    = mbt_q[2];
  assign bus.b_out    = mbt_q[1];
  assign bus.t_out    = mbt_q[0];
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.truth    = truth_q;
  assign bus.match    = match_q;
  assign bus.fail_idx = fail_q;

endmodule

// File: tb/tb_blackbox_sweeper.sv
// Scoreboard bench: two sweepers (SETTLE=2 on an XOR blackbox, SETTLE=1 on m&b|t).
module tb_blackbox_sweeper;

  typedef struct {
    logic [7:0] truth;
    logic       match;
    logic [2:0] fail_idx;
    int         cyc;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  logic p_force_en = 1'b0;
  logic p_force    = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  blackbox_sweeper_if bus0 ();
  blackbox_sweeper_if bus1 ();

  assign bus0.p_in = p_force_en ? p_force : (bus0.m_out ^ bus0.b_out ^ bus0.t_out);
  assign bus1.p_in = (bus1.m_out & bus1.b_out) | bus1.t_out;

  blackbox_sweeper #(.SETTLE(2)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  blackbox_sweeper #(.SETTLE(1)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  function automatic logic [31:0] mbt0();
    return {29'd0, bus0.m_out, bus0.b_out, bus0.t_out};
  endfunction

  // Called at a negedge; start is seen by the next rising edge (E0).
  task automatic launch0(input logic [7:0] expv, input logic [7:0] tr, input logic mt,
                         input logic [2:0] fi, input bit push);
    bus0.expected = expv;
    bus0.start    = 1'b1;
    if (push) q0.push_back('{truth: tr, match: mt, fail_idx: fi, cyc: cyc + 2 + 8 * 2});
    @(negedge clock);
    bus0.start = 1'b0;
  endtask

  task automatic launch1(input logic [7:0] expv, input logic [7:0] tr, input logic mt,
                         input logic [2:0] fi);
    bus1.expected = expv;
    bus1.start    = 1'b1;
    q1.push_back('{truth: tr, match: mt, fail_idx: fi, cyc: cyc + 2 + 8 * 1});
    @(negedge clock);
    bus1.start = 1'b0;
  endtask

  task automatic drain0();
    for (int i = 0; i < 100 && q0.size() != 0; i++) @(negedge clock);
    check("dut0 sweep completed", q0.size(), 0);
    @(negedge clock);
  endtask

  task automatic drain1();
    for (int i = 0; i < 100 && q1.size() != 0; i++) @(negedge clock);
    check("dut1 sweep completed", q1.size(), 0);
    @(negedge clock);
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus0.done) begin
      if (q0.size() == 0) begin
        check("dut0 spurious done", bus0.done, 1'b0);
      end else begin
        e0 = q0.pop_front();
        check("dut0 truth", bus0.truth, e0.truth);
        check("dut0 match", bus0.match, e0.match);
        check("dut0 fail_idx", bus0.fail_idx, e0.fail_idx);
        check("dut0 done cycle", cyc, e0.cyc);
      end
    end
  end

  always @(negedge clock) begin
    if (bus1.done) begin
      if (q1.size() == 0) begin
        check("dut1 spurious done", bus1.done, 1'b0);
      end else begin
        e1 = q1.pop_front();
        check("dut1 truth", bus1.truth, e1.truth);
        check("dut1 match", bus1.match, e1.match);
        check("dut1 fail_idx", bus1.fail_idx, e1.fail_idx);
        check("dut1 done cycle", cyc, e1.cyc);
      end
    end
  end

  initial begin
    int n;
    bus0.start = 1'b0;
    bus0.expected = 8'h00;
    bus1.start = 1'b0;
    bus1.expected = 8'h00;

    repeat (2) @(negedge clock);
    check("reset busy", bus0.busy, 1'b0);
    check("reset done", bus0.done, 1'b0);
    check("reset mbt", mbt0(), 0);
    check("reset truth", bus0.truth, 8'h00);
    check("reset match", bus0.match, 1'b0);
    check("reset fail_idx", bus0.fail_idx, 3'd0);
    check("reset dut1 busy", bus1.busy, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);

    // XOR model, matching golden table, plus the driven vector sequence.
    launch0(8'h96, 8'h96, 1'b1, 3'd0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      check("mbt sequence", mbt0(), 32'((k - 1) / 2));
      check("busy in sweep", bus0.busy, 1'b1);
      @(negedge clock);
    end
    drain0();
    check("busy after done", bus0.busy, 1'b0);

    // Mismatches: lowest and highest failing index.
    launch0(8'h97, 8'h96, 1'b0, 3'd0, 1'b1);
    drain0();
    launch0(8'h16, 8'h96, 1'b0, 3'd7, 1'b1);
    drain0();

    // Results hold while inputs wander with no start.
    p_force_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus0.expected = 8'($urandom);
      p_force = ~p_force;
      @(negedge clock);
      check("hold truth", bus0.truth, 8'h96);
      check("hold match", bus0.match, 1'b0);
      check("hold fail_idx", bus0.fail_idx, 3'd7);
    end
    p_force_en = 1'b0;

    // SETTLE=1 on m&b|t.
    launch1(8'hEA, 8'hEA, 1'b1, 3'd0);
    drain1();
    launch1(8'hE8, 8'hEA, 1'b0, 3'd1);
    drain1();

    // start held high: one sweep, ignored in DONE, restarted in the first IDLE cycle.
    n = cyc;
    bus0.expected = 8'h96;
    bus0.start = 1'b1;
    q0.push_back('{truth: 8'h96, match: 1'b1, fail_idx: 3'd0, cyc: n + 18});
    q0.push_back('{truth: 8'h96, match: 1'b1, fail_idx: 3'd0, cyc: n + 37});
    repeat (20) @(negedge clock);
    bus0.start = 1'b0;
    repeat (6) @(negedge clock);
    // Extra pulse mid-sweep must not clear the partial table.
    bus0.start = 1'b1;
    @(negedge clock);
    bus0.start = 1'b0;
    check("mid-sweep truth kept", bus0.truth, 8'h06);
    check("mid-sweep busy", bus0.busy, 1'b1);
    drain0();
    repeat (3) @(negedge clock);
    check("no extra sweep", bus0.busy, 1'b0);

    // Reset mid-sweep: everything clears at once and no done appears.
    launch0(8'h96, 8'h00, 1'b0, 3'd0, 1'b0);
    repeat (6) @(negedge clock);
    check("pre-reset truth", bus0.truth, 8'h06);
    check("pre-reset mbt", mbt0(), 3);
    #2 reset_n = 1'b0;
    #1;
    check("async reset busy", bus0.busy, 1'b0);
    check("async reset done", bus0.done, 1'b0);
    check("async reset mbt", mbt0(), 0);
    check("async reset truth", bus0.truth, 8'h00);
    check("async reset match", bus0.match, 1'b0);
    check("async reset fail_idx", bus0.fail_idx, 3'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    check("no done after reset", bus0.busy, 1'b0);
    launch0(8'h96, 8'h96, 1'b1, 3'd0, 1'b1);
    drain0();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
